// File: rtl/mdclcg_pkg.sv
// ---------------------------------------------------------------------------
// mdclcg_pkg
// Shared types and constants for the carry-save LCG step engine.
//   state_e    : step engine FSM states
//   cnt_width  : width of the row-group counter for a given group count
//   MMIX_*     : default LCG constants (Knuth MMIX) for benches
// ---------------------------------------------------------------------------
package mdclcg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StResolve
   } state_e;

   // Counter must be at least one bit wide even when only one group is needed.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam logic [63:0] MMIX_MULT = 64'd6364136223846793005;
   localparam logic [63:0] MMIX_INCR = 64'd1442695040888963407;

endpackage

// File: rtl/csa_row.sv
// ---------------------------------------------------------------------------
// csa_row
// One row of bit-parallel 3:2 compressors (full adders).
//   i_a, i_b, i_c : three operands of equal weight
//   o_sum         : per-bit xor of the three operands
//   o_carry       : per-bit majority, unshifted (weight 2 relative to o_sum)
// ---------------------------------------------------------------------------
module csa_row #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   output logic [WIDTH-1:0] o_sum,
   output logic [WIDTH-1:0] o_carry
);

   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_lcg_core.sv
// ---------------------------------------------------------------------------
// csa_lcg_core
// Sequential LCG step engine: x <= (mult * x + incr) mod 2^WIDTH.
// Partial products are folded into a carry-save pair (S, Cy) over
// WIDTH/ROWS_PER_CYCLE cycles; a single carry-propagate add resolves x.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_seed_load      : load i_seed into x (idle only)
//   i_start          : begin one step (idle only); samples i_mult / i_incr
//   i_free_run       : at completion, immediately begin the next step
//   o_busy           : step in progress
//   o_done           : one-cycle pulse when o_rnd takes a new step result
//   o_rnd            : current state x
// ---------------------------------------------------------------------------
module csa_lcg_core
   import mdclcg_pkg::*;
#(
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned ROWS_PER_CYCLE = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed,
   input  logic             i_start,
   input  logic             i_free_run,
   input  logic [WIDTH-1:0] i_mult,
   input  logic [WIDTH-1:0] i_incr,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_rnd
);

   localparam int unsigned N  = WIDTH / ROWS_PER_CYCLE;
   localparam int unsigned CW = cnt_width(N);
   localparam int unsigned IW = $clog2(WIDTH);

   state_e           r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] r_cy;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;

   // Chain of compressor rows; row j handles multiplier bit r_cnt*K + j.
   for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_row
      logic [IW-1:0]    w_idx;
      logic [WIDTH-1:0] w_pp;
      logic [WIDTH-1:0] w_s_in;
      logic [WIDTH-1:0] w_cy_in;
      logic [WIDTH-1:0] w_cy_sh;
      logic [WIDTH-1:0] w_s_out;
      logic [WIDTH-1:0] w_cy_out;

      if (j == 0) begin : g_first
         assign w_s_in  = r_s;
         assign w_cy_in = r_cy;
      end else begin : g_chain
         assign w_s_in  = g_row[j-1].w_s_out;
         assign w_cy_in = g_row[j-1].w_cy_out;
      end

      assign w_idx   = IW'(32'(r_cnt) * ROWS_PER_CYCLE + j);
      assign w_pp    = r_m[w_idx] ? (r_x << w_idx) : '0;
      // Stored carries are unshifted; align them to their true weight here.
      assign w_cy_sh = w_cy_in << 1;

      csa_row #(
         .WIDTH(WIDTH)
      ) u_row (
         .i_a    (w_s_in),
         .i_b    (w_cy_sh),
         .i_c    (w_pp),
         .o_sum  (w_s_out),
         .o_carry(w_cy_out)
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_x     <= '0;
         r_m     <= '0;
         r_c     <= '0;
         r_s     <= '0;
         r_cy    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               // Seed lands in x on the same edge, so the step sees the seed.
               if (i_seed_load) r_x <= i_seed;
               if (i_start) begin
                  r_m     <= i_mult;
                  r_c     <= i_incr;
                  r_s     <= i_incr;
                  r_cy    <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StAccum;
               end
            end
            StAccum: begin
               r_s  <= g_row[ROWS_PER_CYCLE-1].w_s_out;
               r_cy <= g_row[ROWS_PER_CYCLE-1].w_cy_out;
               if (r_cnt == CW'(N - 1)) begin
                  r_state <= StResolve;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StResolve: begin
               r_x    <= r_s + (r_cy << 1);
               r_done <= 1'b1;
               if (i_free_run) begin
                  r_s     <= r_c;
                  r_cy    <= '0;
                  r_cnt   <= '0;
                  r_state <= StAccum;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_rnd  = r_x;

endmodule

// File: tb/tb_csa_lcg_core.sv
// ---------------------------------------------------------------------------
// tb_csa_lcg_core
// Three engine instances (8-bit K=1, 8-bit K=4, 64-bit K=1) sharing clock
// and reset. Expected step results come from a software LCG model and are
// queued when a step is started, then popped when done pulses.
// ---------------------------------------------------------------------------
module tb_csa_lcg_core;
   import mdclcg_pkg::*;

   logic clk;
   logic rst;

   // DUT A: WIDTH=8, K=1
   logic       a_seed_load, a_start, a_free_run;
   logic [7:0] a_seed, a_mult, a_incr, a_rnd;
   logic       a_busy, a_done;
   // DUT B: WIDTH=8, K=4
   logic       b_seed_load, b_start, b_free_run;
   logic [7:0] b_seed, b_mult, b_incr, b_rnd;
   logic       b_busy, b_done;
   // DUT C: WIDTH=64, K=1
   logic        c_seed_load, c_start, c_free_run;
   logic [63:0] c_seed, c_mult, c_incr, c_rnd;
   logic        c_busy, c_done;

   int          n_tests;
   int          n_fail;
   logic [63:0] sb_q[$];
   logic [7:0]  ma;   // model of DUT A state

   csa_lcg_core #(.WIDTH(8), .ROWS_PER_CYCLE(1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_seed_load(a_seed_load), .i_seed(a_seed),
      .i_start(a_start), .i_free_run(a_free_run), .i_mult(a_mult), .i_incr(a_incr),
      .o_busy(a_busy), .o_done(a_done), .o_rnd(a_rnd)
   );

   csa_lcg_core #(.WIDTH(8), .ROWS_PER_CYCLE(4)) u_b (
      .i_clk(clk), .i_rst(rst), .i_seed_load(b_seed_load), .i_seed(b_seed),
      .i_start(b_start), .i_free_run(b_free_run), .i_mult(b_mult), .i_incr(b_incr),
      .o_busy(b_busy), .o_done(b_done), .o_rnd(b_rnd)
   );

   csa_lcg_core #(.WIDTH(64), .ROWS_PER_CYCLE(1)) u_c (
      .i_clk(clk), .i_rst(rst), .i_seed_load(c_seed_load), .i_seed(c_seed),
      .i_start(c_start), .i_free_run(c_free_run), .i_mult(c_mult), .i_incr(c_incr),
      .o_busy(c_busy), .o_done(c_done), .o_rnd(c_rnd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lcg8(input logic [7:0] x, input logic [7:0] m,
                                       input logic [7:0] i);
      logic [7:0] r;
      r = x * m + i;
      return r;
   endfunction

   function automatic logic [63:0] lcg64(input logic [63:0] x, input logic [63:0] m,
                                         input logic [63:0] i);
      logic [63:0] r;
      r = x * m + i;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
      end else begin
         exp = sb_q.pop_front();
         check(tag, obs, exp);
      end
   endtask

   // Advance to #1 after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a done pulse on the selected DUT; cyc = edges taken.
   task automatic wait_done(input int which, input int limit, output int cyc);
      logic d;
      cyc = 0;
      d   = 1'b0;
      while (!d && cyc < limit) begin
         tick();
         cyc++;
         case (which)
            0:       d = a_done;
            1:       d = b_done;
            default: d = c_done;
         endcase
      end
      check($sformatf("done_seen_%0d", which), 64'(d), 64'd1);
   endtask

   // Drive one start on DUT A (optionally with seed_load) and queue the result.
   task automatic start_a(input logic sl, input logic [7:0] sd, input logic [7:0] m,
                          input logic [7:0] i);
      a_seed_load = sl;
      a_seed      = sd;
      a_start     = 1'b1;
      a_mult      = m;
      a_incr      = i;
      if (sl) ma = sd;
      ma = lcg8(ma, m, i);
      sb_q.push_back(64'(ma));
      tick();
      a_start     = 1'b0;
      a_seed_load = 1'b0;
   endtask

   initial begin
      int cyc;
      int seen;
      n_tests = 0;
      n_fail  = 0;
      ma      = '0;
      rst     = 1'b1;
      {a_seed_load, a_start, a_free_run, a_seed, a_mult, a_incr} = '0;
      {b_seed_load, b_start, b_free_run, b_seed, b_mult, b_incr} = '0;
      {c_seed_load, c_start, c_free_run, c_seed, c_mult, c_incr} = '0;

      // Reset state
      #1;
      check("reset_rnd", 64'(a_rnd), 64'd0);
      check("reset_busy", 64'(a_busy), 64'd0);
      check("reset_done", 64'(a_done), 64'd0);
      check("reset_rnd_c", c_rnd, 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Seed load alone
      a_seed_load = 1'b1;
      a_seed      = 8'h01;
      ma          = 8'h01;
      tick();
      a_seed_load = 1'b0;
      check("seed_load_rnd", 64'(a_rnd), 64'h01);

      // First step: latency, result, busy/done handshake
      start_a(1'b0, 8'h00, 8'd5, 8'd3);
      check("busy_after_start", 64'(a_busy), 64'd1);
      wait_done(0, 40, cyc);
      check("latency_w8k1", 64'(cyc), 64'd9);
      pop_check("step1_rnd", 64'(a_rnd));
      check("step1_busy_low", 64'(a_busy), 64'd0);
      tick();
      check("done_one_cycle", 64'(a_done), 64'd0);

      // Second step
      start_a(1'b0, 8'h00, 8'd5, 8'd3);
      wait_done(0, 40, cyc);
      pop_check("step2_rnd", 64'(a_rnd));

      // start/seed_load/mult/incr changes while busy are ignored
      start_a(1'b0, 8'h00, 8'd5, 8'd3);
      tick();
      tick();
      a_start     = 1'b1;
      a_seed_load = 1'b1;
      a_seed      = 8'h77;
      a_mult      = 8'd7;
      a_incr      = 8'd9;
      tick();
      a_start     = 1'b0;
      a_seed_load = 1'b0;
      check("busy_ignore_rnd_stable", 64'(a_rnd), 64'h2B);
      wait_done(0, 40, cyc);
      check("busy_ignore_latency", 64'(cyc + 3), 64'd9);
      pop_check("busy_ignore_rnd", 64'(a_rnd));
      tick();
      check("busy_ignore_no_restart", 64'(a_busy), 64'd0);

      // Simultaneous seed_load and start: step uses the seed
      start_a(1'b1, 8'h02, 8'd5, 8'd3);
      wait_done(0, 40, cyc);
      pop_check("seed_and_start_rnd", 64'(a_rnd));

      // Free-run: four back-to-back steps from seed 1, free_run dropped before the last
      a_seed_load = 1'b1;
      a_seed      = 8'h01;
      ma          = 8'h01;
      tick();
      a_seed_load = 1'b0;
      a_free_run  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ma = lcg8(ma, 8'd5, 8'd3);
         sb_q.push_back(64'(ma));
      end
      a_start = 1'b1;
      a_mult  = 8'd5;
      a_incr  = 8'd3;
      tick();
      a_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) a_free_run = 1'b0;
         wait_done(0, 40, cyc);
         check($sformatf("free_run_period_%0d", k), 64'(cyc), 64'd9);
         pop_check($sformatf("free_run_rnd_%0d", k), 64'(a_rnd));
         check($sformatf("free_run_busy_%0d", k), 64'(a_busy), (k == 3) ? 64'd0 : 64'd1);
      end

      // Wrap-around, WIDTH=8, K=4
      b_seed_load = 1'b1;
      b_seed      = 8'hFF;
      tick();
      b_seed_load = 1'b0;
      b_start     = 1'b1;
      b_mult      = 8'hFF;
      b_incr      = 8'h01;
      sb_q.push_back(64'(lcg8(8'hFF, 8'hFF, 8'h01)));
      tick();
      b_start = 1'b0;
      wait_done(1, 20, cyc);
      check("latency_w8k4", 64'(cyc), 64'd3);
      pop_check("wrap_rnd", 64'(b_rnd));

      // Full-width MMIX step from seed 0
      c_seed_load = 1'b1;
      c_seed      = 64'd0;
      c_start     = 1'b1;
      c_mult      = MMIX_MULT;
      c_incr      = MMIX_INCR;
      sb_q.push_back(lcg64(64'd0, MMIX_MULT, MMIX_INCR));
      tick();
      c_start     = 1'b0;
      c_seed_load = 1'b0;
      wait_done(2, 200, cyc);
      check("latency_w64k1", 64'(cyc), 64'd65);
      pop_check("mmix_rnd", c_rnd);
      check("mmix_rnd_const", c_rnd, 64'h14057B7EF767814F);

      // Reset mid-ACCUM aborts the step with no done pulse
      start_a(1'b0, 8'h00, 8'd5, 8'd3);
      void'(sb_q.pop_back());
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midrst_rnd", 64'(a_rnd), 64'd0);
      check("midrst_busy", 64'(a_busy), 64'd0);
      check("midrst_done", 64'(a_done), 64'd0);
      tick();
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (a_done || a_busy) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      check("midrst_rnd_hold", 64'(a_rnd), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
